barrier_map_writer: RTL and testbench

//  Sequential producer of the obstacle bitmap consumed by the lattice update.
//  On start, raster-scans every cell (hor fastest, then vert) of the HPIXELS x VPIXELS grid.

---
 rtl/barrier_map_writer.sv | 205 ++++++++++++++++++++
 tb/tb_barrier_map_writer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/barrier_map_writer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : barrier_map_writer
// Description : Raster-scans an HPIXELS x VPIXELS grid and streams one
//               {addr, bit} write per cell into the barrier RAM. A bit is 1
//               when the cell lies strictly inside a circle latched at start.
//               Define BARRIER_MAP_WALLS_EN to also force the top and bottom
//               rows to barrier (channel walls).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module barrier_map_writer #(
    parameter int  HPIXELS   = 240,
    parameter int  VPIXELS   = 160,
    parameter int  RAD_W     = 8,
    localparam int HOR_SIZE  = $clog2(HPIXELS),
    localparam int VERT_SIZE = $clog2(VPIXELS),
    localparam int ADDR_W    = $clog2(HPIXELS*VPIXELS)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 start_in,
    input  logic [HOR_SIZE-1:0]  centre_hor_in,
    input  logic [VERT_SIZE-1:0] centre_vert_in,
    input  logic [RAD_W-1:0]     radius_in,
    output logic                 wr_valid_out,
    input  logic                 wr_ready_in,
    output logic [ADDR_W-1:0]    wr_addr_out,
    output logic                 wr_data_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [ADDR_W:0]      cell_count_out
);

    localparam int DX_W  = HOR_SIZE + 1;
    localparam int DY_W  = VERT_SIZE + 1;
    localparam int SQX_W = 2 * DX_W;
    localparam int SQY_W = 2 * DY_W;
    localparam int SUM_W = ((SQX_W > SQY_W) ? SQX_W : SQY_W) + 1;
    localparam int RR_W  = 2 * RAD_W;
    localparam int CMP_W = (SUM_W > RR_W) ? SUM_W : RR_W;

    localparam logic [HOR_SIZE-1:0]  C_HOR_LAST  = HOR_SIZE'(HPIXELS - 1);
    localparam logic [VERT_SIZE-1:0] C_VERT_LAST = VERT_SIZE'(VPIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // S0: coordinate counters and latched circle
    logic [HOR_SIZE-1:0]  r_ctr_h;
    logic [VERT_SIZE-1:0] r_ctr_v;
    logic [ADDR_W-1:0]    r_ctr_addr;
    logic [HOR_SIZE-1:0]  r_cen_h;
    logic [VERT_SIZE-1:0] r_cen_v;
    logic [RAD_W-1:0]     r_rad;

    // S1: absolute distances
    logic                 r_s1_valid, r_s1_last, r_s1_wall;
    logic [ADDR_W-1:0]    r_s1_addr;
    logic [DX_W-1:0]      r_s1_dx;
    logic [DY_W-1:0]      r_s1_dy;

    // S2: squares
    logic                 r_s2_valid, r_s2_last, r_s2_wall;
    logic [ADDR_W-1:0]    r_s2_addr;
    logic [SQX_W-1:0]     r_s2_sqx;
    logic [SQY_W-1:0]     r_s2_sqy;

    // S3: output register
    logic                 r_out_valid, r_out_last, r_out_data;
    logic [ADDR_W-1:0]    r_out_addr;
    logic [ADDR_W:0]      r_cnt;

    logic                 w_start, w_adv, w_issue, w_fire, w_last_cell, w_wall, w_hit;
    logic [DX_W-1:0]      w_dx;
    logic [DY_W-1:0]      w_dy;
    logic [SUM_W-1:0]     w_sum;
    logic [RR_W-1:0]      w_rr;

    assign w_start     = (r_state == S_IDLE) && start_in;
    // A held (unaccepted) output beat freezes every stage behind it.
    assign w_adv       = !r_out_valid || wr_ready_in;
    assign w_issue     = (r_state == S_SCAN) && w_adv;
    assign w_fire      = r_out_valid && wr_ready_in;
    assign w_last_cell = (r_ctr_h == C_HOR_LAST) && (r_ctr_v == C_VERT_LAST);

    assign w_dx = (r_ctr_h >= r_cen_h) ? {1'b0, r_ctr_h - r_cen_h} : {1'b0, r_cen_h - r_ctr_h};
    assign w_dy = (r_ctr_v >= r_cen_v) ? {1'b0, r_ctr_v - r_cen_v} : {1'b0, r_cen_v - r_ctr_v};

`ifdef BARRIER_MAP_WALLS_EN
    assign w_wall = (r_ctr_v == '0) || (r_ctr_v == C_VERT_LAST);
`else
    assign w_wall = 1'b0;
`endif

    assign w_sum = SUM_W'(r_s2_sqx) + SUM_W'(r_s2_sqy);
    assign w_rr  = RR_W'(r_rad) * RR_W'(r_rad);
    assign w_hit = CMP_W'(w_sum) < CMP_W'(w_rr);

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next-state logic; DRAIN waits for the beat tagged as the final cell
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_in)                w_state_nxt = S_SCAN;
            S_SCAN:  if (w_issue && w_last_cell)  w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_fire && r_out_last)    w_state_nxt = S_DONE;
            S_DONE:                               w_state_nxt = S_IDLE;
            default:                              w_state_nxt = S_IDLE;
        endcase
    end

    // Coordinate counters (hor fastest) and circle latch at start
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ctr_h    <= '0;
            r_ctr_v    <= '0;
            r_ctr_addr <= '0;
            r_cen_h    <= '0;
            r_cen_v    <= '0;
            r_rad      <= '0;
        end else if (w_start) begin
            r_ctr_h    <= '0;
            r_ctr_v    <= '0;
            r_ctr_addr <= '0;
            r_cen_h    <= centre_hor_in;
            r_cen_v    <= centre_vert_in;
            r_rad      <= radius_in;
        end else if (w_issue) begin
            r_ctr_addr <= r_ctr_addr + 1'b1;
            if (r_ctr_h == C_HOR_LAST) begin
                r_ctr_h <= '0;
                r_ctr_v <= r_ctr_v + 1'b1;
            end else begin
                r_ctr_h <= r_ctr_h + 1'b1;
            end
        end
    end

    // Three-stage classification pipeline, advancing only when output can move
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_wall   <= 1'b0;
            r_s1_addr   <= '0;
            r_s1_dx     <= '0;
            r_s1_dy     <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_wall   <= 1'b0;
            r_s2_addr   <= '0;
            r_s2_sqx    <= '0;
            r_s2_sqy    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= 1'b0;
            r_out_addr  <= '0;
        end else if (w_adv) begin
            r_s1_valid  <= w_issue;
            r_s1_last   <= w_last_cell;
            r_s1_wall   <= w_wall;
            r_s1_addr   <= r_ctr_addr;
            r_s1_dx     <= w_dx;
            r_s1_dy     <= w_dy;
            r_s2_valid  <= r_s1_valid;
            r_s2_last   <= r_s1_last;
            r_s2_wall   <= r_s1_wall;
            r_s2_addr   <= r_s1_addr;
            r_s2_sqx    <= SQX_W'(r_s1_dx) * SQX_W'(r_s1_dx);
            r_s2_sqy    <= SQY_W'(r_s1_dy) * SQY_W'(r_s1_dy);
            r_out_valid <= r_s2_valid;
            r_out_last  <= r_s2_last;
            r_out_data  <= w_hit || r_s2_wall;
            r_out_addr  <= r_s2_addr;
        end
    end

    // Barrier-cell counter: cleared at start, held after the scan
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)                 r_cnt <= '0;
        else if (w_start)              r_cnt <= '0;
        else if (w_fire && r_out_data) r_cnt <= r_cnt + 1'b1;
    end

    assign wr_valid_out   = r_out_valid;
    assign wr_addr_out    = r_out_addr;
    assign wr_data_out    = r_out_data;
    assign busy_out       = (r_state == S_SCAN) || (r_state == S_DRAIN);
    assign done_out       = (r_state == S_DONE);
    assign cell_count_out = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_barrier_map_writer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_barrier_map_writer
// Description : Self-checking bench for barrier_map_writer on an 8x4 grid.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_barrier_map_writer;

    localparam int HP = 8;
    localparam int VP = 4;
    localparam int RW = 4;
    localparam int NC = HP * VP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] cen_h = '0;
    logic [1:0] cen_v = '0;
    logic [3:0] rad = '0;
    logic       valid;
    logic       ready = 1'b1;
    logic [4:0] addr;
    logic       data;
    logic       busy;
    logic       done;
    logic [5:0] count;

    int n_cmp = 0;
    int n_err = 0;

    barrier_map_writer #(.HPIXELS(HP), .VPIXELS(VP), .RAD_W(RW)) u_dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .start_in       (start),
        .centre_hor_in  (cen_h),
        .centre_vert_in (cen_v),
        .radius_in      (rad),
        .wr_valid_out   (valid),
        .wr_ready_in    (ready),
        .wr_addr_out    (addr),
        .wr_data_out    (data),
        .busy_out       (busy),
        .done_out       (done),
        .cell_count_out (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: a cell is barrier when strictly inside the circle (or a wall row)
    function automatic bit ref_bit(int h, int v, int ch, int cv, int r);
        int dx = h - ch;
        int dy = v - cv;
        bit b = (dx*dx + dy*dy) < (r*r);
`ifdef BARRIER_MAP_WALLS_EN
        if (v == 0 || v == VP-1) b = 1'b1;
`endif
        return b;
    endfunction

    // mode: 0 ready=1, 1 random ready, 2 stall 5 cycles at addr 10,
    //       3 re-pulse start at addr 5, 4 reset at addr 17
    task automatic run_scan(input int ch, input int cv, input int r, input int mode);
        bit   expb[NC];
        int   exp_cnt = 0;
        int   beats = 0, dones = 0, cyc = 0, tail = 0, low_cnt = 0;
        bit   prev_stall = 0, pulsed = 0;
        logic [4:0] paddr = '0;
        logic pdata = 1'b0;
        for (int i = 0; i < NC; i++) begin
            expb[i] = ref_bit(i % HP, i / HP, ch, cv, r);
            exp_cnt += int'(expb[i]);
        end
        @(negedge clk);
        cen_h = 3'(ch); cen_v = 2'(cv); rad = 4'(r);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        // Scrambling inputs mid-scan must not alter the result
        cen_h = 3'($urandom); cen_v = 2'($urandom); rad = 4'($urandom);
        while (cyc < 600 && tail < 3) begin
            if (prev_stall) begin
                check("hold_valid", valid, 1);
                check("hold_addr", addr, paddr);
                check("hold_data", data, pdata);
            end
            if (done) dones++;
            if (dones > 0) tail++;
            if (mode == 4 && valid && addr == 5'd17) begin
                rst_n = 1'b0;
                #1;
                check("rst_valid", valid, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                @(negedge clk);
                rst_n = 1'b1;
                ready = 1'b1;
                return;
            end
            case (mode)
                1: ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (valid && addr == 5'd10 && low_cnt < 5) begin
                        ready = 1'b0;
                        low_cnt++;
                    end else ready = 1'b1;
                end
                default: ready = 1'b1;
            endcase
            if (mode == 3) begin
                if (valid && addr == 5'd5 && !pulsed) begin
                    start = 1'b1;
                    cen_h = 3'($urandom); rad = 4'($urandom);
                    pulsed = 1;
                end else start = 1'b0;
            end
            if (valid && ready) begin
                check("addr", addr, beats);
                if (beats < NC) check("data", data, expb[beats]);
                beats++;
            end
            prev_stall = valid && !ready;
            paddr = addr;
            pdata = data;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b1;
        check("timeout", cyc < 600, 1);
        check("beats", beats, NC);
        check("done_pulses", dones, 1);
        check("cell_count", count, exp_cnt);
        check("busy_idle", busy, 0);
        check("valid_idle", valid, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_valid", valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_count", count, 0);
        rst_n = 1'b1;

        run_scan(3, 2, 2, 0);   // centred circle
        run_scan(0, 0, 2, 0);   // off-grid clip at a corner
        run_scan(5, 1, 0, 0);   // zero radius
        run_scan(4, 1, 3, 2);   // backpressure at addr 10
        run_scan(6, 3, 2, 3);   // start re-pulse ignored
        run_scan(2, 1, 3, 4);   // reset mid-scan
        check("post_rst_count", count, 0);
        run_scan(2, 1, 3, 0);   // fresh scan after reset
        for (int k = 0; k < 6; k++)
            run_scan($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
